brlwe_serial_dec: RTL



---
 rtl/brlwe_serial_dec_if.sv | 33 +++
 rtl/brlwe_serial_dec.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/brlwe_serial_dec_if.sv
// brlwe_serial_dec_if: load/start/operand and result bundle.
// coef_out exists only when BRLWE_DEC_COEF_EN is defined.
interface brlwe_serial_dec_if #(
  parameter int QW = 8
);
  logic          load;
  logic          start;
  logic          r2_in;
  logic [QW-1:0] c1_in;
  logic [QW-1:0] c2_in;
  logic          message_out;
  logic          valid;
  logic          busy;
`ifdef BRLWE_DEC_COEF_EN
  logic [QW-1:0] coef_out;
`endif

  modport master (
    output load, start, r2_in, c1_in, c2_in,
`ifdef BRLWE_DEC_COEF_EN
    input  coef_out,
`endif
    input  message_out, valid, busy
  );

  modport slave (
    input  load, start, r2_in, c1_in, c2_in,
`ifdef BRLWE_DEC_COEF_EN
    output coef_out,
`endif
    output message_out, valid, busy
  );
endinterface

// File: rtl/brlwe_serial_dec.sv
// brlwe_serial_dec: serial binary Ring-LWE decryption, one MAC per clock.
// Optional macro BRLWE_DEC_COEF_EN adds the raw coefficient output coef_out.
module brlwe_serial_dec #(
  parameter int N  = 256,
  parameter int QW = 8
) (
  input  logic clk,
  input  logic resetn,
  brlwe_serial_dec_if.slave bus
);
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]  r2_q;
  logic [QW-1:0] c1_q [N];
  logic [QW-1:0] c2_q [N];

  logic [AW-1:0] widx_q;
  logic [AW-1:0] i_q;
  logic [AW-1:0] j_q;
  logic [QW-1:0] acc_q;
  logic          msg_q;
  logic          valid_q;
  logic          busy_q;

  logic          idle_like;
  logic          wr_en;
  logic          start_ok;
  logic          last_j;
  logic          last_i;
  logic [AW-1:0] k_idx;
  logic [QW-1:0] op;
  logic [QW-1:0] mac_nxt;

  assign idle_like = (state_q == IDLE) || (state_q == LOAD);
  assign wr_en     = idle_like & bus.load;
  assign start_ok  = idle_like & bus.start & ~bus.load;
  assign last_j    = (j_q == AW'(N - 1));
  assign last_i    = (i_q == AW'(N - 1));
  // i-j wraps mod N, which also gives i-j+N for the negacyclic term
  assign k_idx     = i_q - j_q;
  assign op        = c1_q[k_idx];

  // Accumulate step: add below the diagonal, subtract on the wrap
  always_comb begin
    mac_nxt = acc_q;
    if (r2_q[j_q]) begin
      if (j_q <= i_q) mac_nxt = acc_q + op;
      else            mac_nxt = acc_q - op;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (start_ok)     state_d = MAC;
        else if (bus.load) state_d = LOAD;
        else              state_d = IDLE;
      end
      MAC:     if (last_j) state_d = OUT;
      OUT:     state_d = last_i ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Operand storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r2_q[widx_q] <= bus.r2_in;
      c1_q[widx_q] <= bus.c1_in;
      c2_q[widx_q] <= bus.c2_in;
    end
  end

  // Counters, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      widx_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      msg_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= (state_q == OUT);
      busy_q  <= (state_q == MAC) || (state_q == OUT);
      if (idle_like) widx_q <= bus.load ? widx_q + AW'(1) : '0;
      if (start_ok) begin
        i_q   <= '0;
        j_q   <= '0;
        acc_q <= c2_q[0];
      end
      if (state_q == MAC) begin
        acc_q <= mac_nxt;
        j_q   <= j_q + AW'(1);
      end
      if (state_q == OUT) begin
        msg_q <= acc_q[QW-1] ^ acc_q[QW-2];
        if (!last_i) begin
          i_q   <= i_q + AW'(1);
          j_q   <= '0;
          acc_q <= c2_q[i_q + AW'(1)];
        end
      end
    end
  end

`ifdef BRLWE_DEC_COEF_EN
  logic [QW-1:0] coef_q;

  // Raw coefficient capture on each valid
  always_ff @(posedge clk) begin
    if (!resetn)             coef_q <= '0;
    else if (state_q == OUT) coef_q <= acc_q;
  end

  assign bus.coef_out = coef_q;
`endif

  assign bus.message_out = msg_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy_q;
endmodule
